// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array host-side feeder.
package systolic_pkg;

    localparam int N        = 4;
    localparam int DATA_W   = 4;
    localparam int RES_W    = 8;
    localparam int LOAD_LEN = 16;

    typedef enum logic [2:0] {
        ST_FILL   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_LOAD_I = 3'd2,
        ST_WAIT   = 3'd3,
        ST_OUT    = 3'd4
    } feeder_state_t;

    typedef logic [N*RES_W-1:0] res_vec_t;

endpackage

// File: rtl/feeder_buf.sv
// Job buffer: register file with one synchronous write port and one asynchronous read port.
module feeder_buf #(
    parameter int DATA_W = 4,
    parameter int AW     = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [0:(1<<AW)-1];

    // Contents are deliberately not reset; every job overwrites all entries before replay.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/systolic_feeder.sv
// Buffers one 32-nibble job, replays it to the 4x4 systolic array as a gap-free burst,
// then returns the captured results downstream through a valid/ready handshake.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int RES_W   = 8,
    parameter int TIMEOUT = 31
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DATA_W-1:0]    s_data,
    output logic [DATA_W-1:0]    arr_data_in,
    output logic                 arr_load_weights,
    output logic                 arr_load_inputs,
    input  logic [N*RES_W-1:0]   arr_results,
    input  logic                 arr_valid_out,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [N*RES_W-1:0]   m_data,
    output logic                 busy,
    output logic                 err
);

    feeder_state_t state_q, state_d;

    logic [4:0]          wptr_q, wptr_d;
    logic [4:0]          rptr_q, rptr_d;
    logic [5:0]          wait_q, wait_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                load_w_q, load_w_d;
    logic                load_i_q, load_i_d;
    logic                err_q, err_d;
    logic [N*RES_W-1:0]  res_q, res_d;

    logic                buf_we_s;
    logic [4:0]          raddr_s;
    logic [DATA_W-1:0]   rdata_s;

    feeder_buf #(
        .DATA_W (DATA_W),
        .AW     (5)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we_s),
        .waddr (wptr_q),
        .wdata (s_data),
        .raddr (raddr_s),
        .rdata (rdata_s)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; rptr_q holds the index of the nibble to present on the next edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: begin
                if (s_valid && (wptr_q == 5'd31)) begin
                    state_d = ST_LOAD_W;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_LOAD_W, ST_LOAD_I: begin
                if (rptr_q == 5'd0) begin
                    state_d = ST_WAIT;
                end else if (rptr_q >= 5'(LOAD_LEN)) begin
                    state_d = ST_LOAD_I;
                end else begin
                    state_d = ST_LOAD_W;
                end
            end
            ST_WAIT: begin
                if (arr_valid_out) begin
                    state_d = ST_OUT;
                end else if (wait_q == 6'(TIMEOUT)) begin
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_OUT: begin
                if (m_ready) begin
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // Datapath next values; array pins are computed from the next state so they change on the same edge.
    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        wait_d   = wait_q;
        data_d   = '0;
        load_w_d = 1'b0;
        load_i_d = 1'b0;
        err_d    = 1'b0;
        res_d    = res_q;
        buf_we_s = 1'b0;
        raddr_s  = rptr_q;
        case (state_q)
            ST_FILL: begin
                buf_we_s = s_valid;
                raddr_s  = 5'd0;
                if (s_valid) begin
                    wptr_d = wptr_q + 5'd1;
                end else begin
                    wptr_d = wptr_q;
                end
                if (state_d == ST_LOAD_W) begin
                    data_d   = rdata_s;
                    load_w_d = 1'b1;
                    rptr_d   = 5'd1;
                end else begin
                    rptr_d   = 5'd0;
                end
            end
            ST_LOAD_W, ST_LOAD_I: begin
                if (state_d == ST_WAIT) begin
                    rptr_d = 5'd0;
                    wait_d = 6'd0;
                end else begin
                    data_d   = rdata_s;
                    load_w_d = (state_d == ST_LOAD_W);
                    load_i_d = (state_d == ST_LOAD_I);
                    rptr_d   = rptr_q + 5'd1;
                end
            end
            ST_WAIT: begin
                if (state_d == ST_OUT) begin
                    res_d = arr_results;
                end else if (state_d == ST_FILL) begin
                    err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 6'd1;
                end
            end
            ST_OUT: begin
                res_d = res_q;
            end
            default: begin
                res_d = res_q;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q   <= 5'd0;
            rptr_q   <= 5'd0;
            wait_q   <= 6'd0;
            data_q   <= '0;
            load_w_q <= 1'b0;
            load_i_q <= 1'b0;
            err_q    <= 1'b0;
            res_q    <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            wait_q   <= wait_d;
            data_q   <= data_d;
            load_w_q <= load_w_d;
            load_i_q <= load_i_d;
            err_q    <= err_d;
            res_q    <= res_d;
        end
    end

    assign s_ready          = (state_q == ST_FILL);
    assign busy             = (state_q != ST_FILL);
    assign m_valid          = (state_q == ST_OUT);
    assign m_data           = res_q;
    assign arr_data_in      = data_q;
    assign arr_load_weights = load_w_q;
    assign arr_load_inputs  = load_i_q;
    assign err              = err_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: nibbles and results are queued as driven, popped as observed.
module tb_systolic_feeder;
    import systolic_pkg::*;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic [3:0]          s_data = 4'd0;
    logic [3:0]          arr_data_in;
    logic                arr_load_weights;
    logic                arr_load_inputs;
    logic [31:0]         arr_results = 32'd0;
    logic                arr_valid_out = 1'b0;
    logic                m_valid;
    logic                m_ready = 1'b0;
    logic [31:0]         m_data;
    logic                busy;
    logic                err;

    int                  errors = 0;
    int                  checks = 0;
    logic [3:0]          exp_q[$];
    res_vec_t            res_q[$];
    res_vec_t            last_res = 32'd0;
    logic [3:0]          job [32];

    systolic_feeder dut (
        .clk              (clk),
        .reset            (reset),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_data           (s_data),
        .arr_data_in      (arr_data_in),
        .arr_load_weights (arr_load_weights),
        .arr_load_inputs  (arr_load_inputs),
        .arr_results      (arr_results),
        .arr_valid_out    (arr_valid_out),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_data           (m_data),
        .busy             (busy),
        .err              (err)
    );

    always #5 clk = ~clk;

    task automatic send_job(input logic [3:0] nib [32], input int max_gap);
        for (int i = 0; i < 32; i++) begin
            int g;
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (g) begin
                s_valid = 1'b0;
                s_data  = 4'($urandom);
                @(posedge clk); #1;
            end
            s_valid = 1'b1;
            s_data  = nib[i];
            exp_q.push_back(nib[i]);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic run_burst(input string tag);
        logic [5:0] got;
        logic [5:0] exp;
        logic [3:0] exp_nib;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            exp_nib = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
            exp = {(k < 16) ? 1'b1 : 1'b0, (k >= 16) ? 1'b1 : 1'b0, exp_nib};
            got = {arr_load_weights, arr_load_inputs, arr_data_in};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s beat %0d: {lw,li,data} got %b expected %b", tag, k, got, exp);
            end
        end
        @(negedge clk);
        checks++;
        if ({arr_load_weights, arr_load_inputs, busy, s_ready} !== 4'b0010) begin
            errors++;
            $display("FAIL %s burst end: {lw,li,busy,s_ready} got %b expected 0010",
                     tag, {arr_load_weights, arr_load_inputs, busy, s_ready});
        end
    endtask

    task automatic respond_and_drain(input string tag, input int delay, input res_vec_t val, input int hold);
        res_vec_t exp;
        repeat (delay) @(posedge clk);
        #1;
        arr_results   = val;
        arr_valid_out = 1'b1;
        res_q.push_back(val);
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s early m_valid: got %b expected 0", tag, m_valid);
        end
        @(posedge clk); #1;
        arr_valid_out = 1'b0;
        arr_results   = ~val;
        @(negedge clk);
        exp = res_q.pop_front();
        last_res = exp;
        checks++;
        if ({m_valid, s_ready, busy, err, m_data} !== {4'b1010, exp}) begin
            errors++;
            $display("FAIL %s capture: {mv,sr,busy,err,m_data} got %b_%h expected 1010_%h",
                     tag, {m_valid, s_ready, busy, err}, m_data, exp);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checks++;
            if ({m_valid, s_ready, m_data} !== {2'b10, exp}) begin
                errors++;
                $display("FAIL %s hold %0d: {mv,sr} got %b m_data %h expected 10 %h",
                         tag, h, {m_valid, s_ready}, m_data, exp);
            end
        end
        s_valid = 1'b0;
        @(posedge clk); #1;
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({s_ready, m_valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL %s release: {sr,mv,busy} got %b expected 100", tag, {s_ready, m_valid, busy});
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({s_ready, busy, m_valid, err, arr_load_weights, arr_load_inputs, arr_data_in, m_data}
            !== {6'b100000, 4'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_values: got %b %h %h expected 100000 0 0",
                     {s_ready, busy, m_valid, err, arr_load_weights, arr_load_inputs}, arr_data_in, m_data);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_ordering;
        for (int i = 0; i < 16; i++) begin
            job[i]      = 4'(i);
            job[i + 16] = 4'(15 - i);
        end
        send_job(job, 0);
        run_burst("ordering");
        respond_and_drain("ordering", 5, 32'hCAFE_0123, 0);
    endtask

    task automatic test_gaps;
        for (int i = 0; i < 32; i++) job[i] = 4'($urandom);
        send_job(job, 3);
        run_burst("gaps");
        respond_and_drain("gaps", 2, 32'h1357_9BDF, 0);
    endtask

    task automatic test_capture;
        for (int i = 0; i < 32; i++) job[i] = 4'($urandom);
        send_job(job, 1);
        run_burst("capture");
        respond_and_drain("capture", 11, 32'h4433_2211, 0);
    endtask

    task automatic test_backpressure;
        for (int i = 0; i < 32; i++) job[i] = 4'($urandom);
        send_job(job, 0);
        s_valid = 1'b1;
        s_data  = 4'hF;
        run_burst("backpressure");
        respond_and_drain("backpressure", 7, 32'hA5A5_5A5A, 10);
    endtask

    task automatic test_timeout;
        int pulses;
        int first_at;
        pulses   = 0;
        first_at = -1;
        for (int i = 0; i < 32; i++) job[i] = 4'(i * 3);
        send_job(job, 0);
        run_burst("timeout");
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            if (err === 1'b1) begin
                pulses++;
                if (first_at < 0) first_at = c;
            end
        end
        checks++;
        if (pulses !== 1 || first_at !== 32) begin
            errors++;
            $display("FAIL timeout_err: pulses %0d at %0d expected 1 at 32", pulses, first_at);
        end
        checks++;
        if ({s_ready, m_valid, busy, m_data} !== {3'b100, last_res}) begin
            errors++;
            $display("FAIL timeout_return: {sr,mv,busy} got %b m_data %h expected 100 %h",
                     {s_ready, m_valid, busy}, m_data, last_res);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout_edge;
        for (int i = 0; i < 32; i++) job[i] = 4'($urandom);
        send_job(job, 0);
        run_burst("timeout_edge");
        respond_and_drain("timeout_edge", 31, 32'h0F1E_2D3C, 0);
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 32; i++) job[i] = 4'($urandom);
        send_job(job, 0);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({s_ready, busy, m_valid, err, arr_load_weights, arr_load_inputs, arr_data_in, m_data}
            !== {6'b100000, 4'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_mid: got %b %h %h expected 100000 0 0",
                     {s_ready, busy, m_valid, err, arr_load_weights, arr_load_inputs}, arr_data_in, m_data);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) job[i] = 4'(31 - i);
        send_job(job, 2);
        run_burst("after_reset");
        respond_and_drain("after_reset", 3, 32'hDEAD_BEEF, 2);
    endtask

    initial begin
        test_reset();
        test_ordering();
        test_gaps();
        test_capture();
        test_backpressure();
        test_timeout();
        test_timeout_edge();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Host-side driver for the 4x4 output-stationary systolic array. It buffers one job of 16 weight nibbles and 16 input nibbles from an upstream valid/ready stream. It then replays them to the array as one gap-free 32-cycle burst on the array's `data_in`/`load_weights`/`load_inputs` pins. Finally it captures the four 8-bit results on `valid_out` and returns them downstream through a valid/ready handshake. Buffering is mandatory: any cycle where neither load strobe nor compute is active clears the array's load counter.

## Interface
Parameters:
- `DATA_W`, default 4: nibble width on both the upstream stream and the array.
- `RES_W`, default 8: width of each array result.
- `TIMEOUT`, default 31: maximum number of WAIT cycles allowed for `arr_valid_out`.

Ports:
- `clk`  in  1  system clock; the block has one clock.
- `reset`  in  1  asynchronous, active-high reset.
- `s_valid`  in  1  upstream nibble valid.
- `s_ready`  out  1  upstream ready; high only in FILL.
- `s_data`  in  DATA_W  upstream nibble. Nibbles 0-15 are weights and nibbles 16-31 are inputs, each in array load order.
- `arr_data_in`  out  DATA_W  drives the array `data_in`; registered.
- `arr_load_weights`  out  1  drives the array `load_weights`; registered.
- `arr_load_inputs`  out  1  drives the array `load_inputs`; registered.
- `arr_results`  in  4xRES_W  array `results[0:3]`.
- `arr_valid_out`  in  1  array `valid_out`.
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  downstream ready.
- `m_data`  out  4*RES_W  packed results; `results[0]` occupies bits [7:0], `results[3]` occupies bits [31:24].
- `busy`  out  1  high in every state except FILL.
- `err`  out  1  one-cycle pulse when the WAIT timeout expires.

## Operation
States are FILL, LOAD_W, LOAD_I, WAIT and OUT.
- **FILL**
  - `s_ready`=1. Each `s_valid && s_ready` cycle writes `s_data` to `buf[wptr]` and increments the 5-bit `wptr`.
  - Upstream gaps (`s_valid`=0) are allowed and have no effect.
  - The handshake that writes entry 31 moves the state to LOAD_W, clears `rptr` and wraps `wptr` to 0.
- **LOAD_W**: `arr_load_weights`=1, `arr_data_in`=`buf[rptr]`, `rptr`++. After 16 cycles, go to LOAD_I with no idle cycle in between.
- **LOAD_I**: `arr_load_inputs`=1, `arr_data_in`=`buf[rptr]`. After 16 cycles, go to WAIT and drop both strobes.
- **WAIT**
  - A 6-bit counter increments every cycle.
  - If `arr_valid_out`=1, latch `arr_results` into `m_data` and go to OUT.
  - Otherwise, when the counter reaches TIMEOUT, pulse `err` and go to FILL. `m_data` is left unchanged.
- **OUT**: `m_valid`=1 and `m_data` is held stable. On `m_ready`, go to FILL.
- `arr_valid_out` is ignored in every state other than WAIT.
- `s_valid` is ignored outside FILL; no data is accepted.
- A reset at any point clears all state and does not flush the buffer contents. A partial job is discarded.

## Timing
- Reset values:
  - state=FILL.
  - `s_ready`=1.
  - `arr_data_in`=0, `arr_load_weights`=0, `arr_load_inputs`=0.
  - `m_valid`=0, `m_data`=0.
  - `busy`=0, `err`=0.
  - `wptr`=0, `rptr`=0, WAIT counter=0.
- With the last upstream handshake at edge T:
  - `arr_load_weights` is high for cycles T+1..T+16.
  - `arr_load_inputs` is high for cycles T+17..T+32.
  - WAIT begins at T+33.
- `arr_valid_out` sampled at edge V gives `m_valid`=1 after V.
- An `m_ready` handshake at edge R gives `s_ready`=1 after R. Back-to-back jobs therefore have a one-cycle OUT minimum.
- The array must see 32 consecutive strobed cycles. No bubble between LOAD_W and LOAD_I is permitted.
- `err` and the transition to OUT are mutually exclusive. If `arr_valid_out` arrives on the timeout cycle, the capture wins.

## Structure
- Shared package `systolic_pkg` holds:
  - `N`=4, `DATA_W`, `RES_W`, `LOAD_LEN`=16.
  - the `feeder_state_t` enum.
  - the packed result typedef `res_vec_t` (4*RES_W).
- Sub-module `feeder_buf` is a 32xDATA_W register file. It has one synchronous write port (`we`, `waddr`) and one asynchronous read port (`raddr`).

## Test plan
- **Ordering**: send `s_data`=0..15 then 15..0 contiguously. `arr_data_in` must show 0..15 with `arr_load_weights`=1 for 16 cycles, then 15..0 with `arr_load_inputs`=1 for 16 cycles, with no bubble.
- **Upstream gaps**: randomly deassert `s_valid` during FILL. The array burst must still be exactly 32 contiguous strobed cycles.
- **Capture**: an array model returns `{8'h44,8'h33,8'h22,8'h11}` with `valid_out` 12 cycles into WAIT. `m_data` must equal 32'h44332211 and `m_valid` must rise one cycle later.
- **Backpressure**: hold `m_ready`=0 for 10 cycles. `m_data` and `m_valid` must stay stable, and `s_ready` must stay 0. When `m_ready` goes to 1, `s_ready` must be 1 on the next cycle.
- **Timeout**: the array model never asserts `valid_out`. `err` must pulse once, 32 cycles after WAIT entry, and the block must return to FILL with `s_ready`=1 and `m_valid`=0.
- **Reset mid-operation**: assert `reset` on the 5th LOAD_W cycle. All outputs must be at their reset values immediately. A full new job after release must replay correctly.
